// File: rtl/upg_uart_loader.sv
// ============================================================================
// Module   : upg_uart_loader
// Purpose  : 8N1 UART receiver plus a loader FSM that assembles little-endian
//            words and drives the upg_* memory write port. Defining
//            UPG_CHECKSUM_EN adds a trailing mod-256 checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module upg_uart_loader #(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 14
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] C_DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN0 = 3'd0,
    LD_LEN1 = 3'd1,
    LD_DATA = 3'd2,
`ifdef UPG_CHECKSUM_EN
    LD_CSUM = 3'd3,
`endif
    LD_DONE = 3'd4,
    LD_ERR  = 3'd5
  } ld_state_t;

  rx_state_t       rx_state_q;
  logic [1:0]      rx_sync_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic            rx_s;

  assign rx_s = rx_sync_q[1];

  // Receiver: start bit re-checked at mid-bit, data/stop sampled every DIV cycles
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      rx_state_q   <= RX_IDLE;
      rx_sync_q    <= 2'b11;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[0], rx_i};
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            cnt_q      <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == C_HALF_M1) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == C_DIV_M1) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_s, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == C_DIV_M1) begin
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s) byte_valid_q <= 1'b1;
            else      frame_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  ld_state_t   ld_state_q;
  logic [15:0] len_q;
  logic [15:0] widx_q;
  logic [1:0]  bidx_q;
  logic [23:0] word_q;
  logic        wen_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0] dat_q;
  logic        done_q;
  logic        err_q;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      ld_state_q <= LD_LEN0;
      len_q      <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      wen_q <= 1'b0;
      if (ld_state_q == LD_DONE) done_q <= 1'b1;
      if (frame_err_q && ld_state_q != LD_DONE) begin
        ld_state_q <= LD_ERR;
        err_q      <= 1'b1;
      end else if (byte_valid_q) begin
        case (ld_state_q)
          LD_LEN0: begin
            len_q[7:0] <= shreg_q;
            ld_state_q <= LD_LEN1;
          end
          LD_LEN1: begin
            len_q[15:8] <= shreg_q;
            widx_q      <= '0;
            bidx_q      <= '0;
`ifdef UPG_CHECKSUM_EN
            sum_q       <= '0;
            ld_state_q  <= ({shreg_q, len_q[7:0]} == 16'd0) ? LD_CSUM : LD_DATA;
`else
            if ({shreg_q, len_q[7:0]} == 16'd0) begin
              ld_state_q <= LD_DONE;
              done_q     <= 1'b1;
            end else begin
              ld_state_q <= LD_DATA;
            end
`endif
          end
          LD_DATA: begin
`ifdef UPG_CHECKSUM_EN
            sum_q <= sum_q + shreg_q;
`endif
            bidx_q <= bidx_q + 1'b1;
            case (bidx_q)
              2'd0: word_q[7:0]   <= shreg_q;
              2'd1: word_q[15:8]  <= shreg_q;
              2'd2: word_q[23:16] <= shreg_q;
              default: begin
                dat_q  <= {shreg_q, word_q};
                adr_q  <= ADDR_W'(widx_q);
                wen_q  <= 1'b1;
                widx_q <= widx_q + 1'b1;
                if (widx_q == len_q - 16'd1) begin
`ifdef UPG_CHECKSUM_EN
                  ld_state_q <= LD_CSUM;
`else
                  ld_state_q <= LD_DONE;
`endif
                end
              end
            endcase
          end
`ifdef UPG_CHECKSUM_EN
          LD_CSUM: begin
            if (shreg_q == sum_q) begin
              ld_state_q <= LD_DONE;
              done_q     <= 1'b1;
            end else begin
              ld_state_q <= LD_ERR;
              err_q      <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_upg_uart_loader.sv
// ============================================================================
// Module   : tb_upg_uart_loader
// Purpose  : Self-checking bench for upg_uart_loader (DIV=4, ADDR_W=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_upg_uart_loader;

  localparam int DIV    = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              upg_wen;
  logic [ADDR_W-1:0] upg_adr;
  logic [31:0]       upg_dat;
  logic              upg_done;
  logic              err;

  upg_uart_loader #(.CLK_HZ(400), .BAUD(100), .ADDR_W(ADDR_W)) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .rx_i      (rx),
    .upg_wen_o (upg_wen),
    .upg_adr_o (upg_adr),
    .upg_dat_o (upg_dat),
    .upg_done_o(upg_done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  longint     cyc = 0;
  longint     last_wen_cyc = 0;
  longint     done_cyc = -1;
  bit         clash = 0;
  logic [31:0] wr_adr[$];
  logic [31:0] wr_dat[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (upg_wen) begin
      wr_adr.push_back(32'(upg_adr));
      wr_dat.push_back(upg_dat);
      last_wen_cyc = cyc;
    end
    if (upg_done && done_cyc < 0) done_cyc = cyc;
    if (upg_wen && upg_done) clash = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("rst_wen",  32'(upg_wen),  0);
    chk("rst_adr",  32'(upg_adr),  0);
    chk("rst_dat",  upg_dat,       0);
    chk("rst_done", 32'(upg_done), 0);
    chk("rst_err",  32'(err),      0);
    #1;
    wr_adr.delete();
    wr_dat.delete();
    done_cyc = -1;
    clash    = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) begin
      send_byte(s[i], 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3 * DIV + 8) @(negedge clk);
  endtask

  // Reference stream: 16-bit count, little-endian words, optional checksum
  task automatic build_stream(input logic [31:0] w[$], output logic [7:0] s[$]);
    logic [15:0] n;
    logic [7:0]  sum;
    n   = 16'(w.size());
    sum = 8'h00;
    s.delete();
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    foreach (w[i]) begin
      for (int k = 0; k < 4; k++) begin
        s.push_back(w[i][8*k +: 8]);
        sum = sum + w[i][8*k +: 8];
      end
    end
`ifdef UPG_CHECKSUM_EN
    s.push_back(sum);
`endif
  endtask

  // Expected result of a complete load: word i lands at address i mod 2^ADDR_W
  task automatic check_load(input string tag, input logic [31:0] w[$]);
    chk({tag, "_nwr"}, 32'(wr_adr.size()), 32'(w.size()));
    for (int i = 0; i < w.size() && i < wr_adr.size(); i++) begin
      chk({tag, "_adr"}, wr_adr[i], 32'(i % (1 << ADDR_W)));
      chk({tag, "_dat"}, wr_dat[i], w[i]);
    end
    chk({tag, "_done"},  32'(upg_done), 1);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_clash"}, 32'(clash), 0);
    if (w.size() > 0)
      chk({tag, "_dlat"}, 32'(done_cyc - last_wen_cyc), 1);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int          n;
    int          bad;

    do_reset();

    // Two-word load
    w = '{32'h12345678, 32'hDEADBEEF};
    build_stream(w, s);
    send_stream(s);
    check_load("two", w);

    // Start-bit glitch, then a normal load
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("gl_nwr",  32'(wr_adr.size()), 0);
    chk("gl_done", 32'(upg_done), 0);
    chk("gl_err",  32'(err), 0);
    w = '{32'hCAFEF00D};
    build_stream(w, s);
    send_stream(s);
    check_load("glitch", w);

    // Framing error on third data byte
    do_reset();
    s = '{8'h03, 8'h00, 8'h11, 8'h22};
    send_stream(s);
    send_byte(8'h33, 1'b1);
    s = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    send_stream(s);
    chk("fe_err",  32'(err), 1);
    chk("fe_nwr",  32'(wr_adr.size()), 0);
    chk("fe_done", 32'(upg_done), 0);

    // Reset mid-word
    do_reset();
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_stream(s);
    do_reset();
    w = '{32'h44332211};
    build_stream(w, s);
    send_stream(s);
    check_load("rmw", w);

    // Zero length with trailing bytes
    do_reset();
    w.delete();
    build_stream(w, s);
    s.push_back(8'h01); s.push_back(8'h00);
    s.push_back(8'h12); s.push_back(8'h34);
    s.push_back(8'h56); s.push_back(8'h78);
    send_stream(s);
    check_load("zero", w);

`ifdef UPG_CHECKSUM_EN
    // Wrong checksum
    do_reset();
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_stream(s);
    chk("cs_err",  32'(err), 1);
    chk("cs_done", 32'(upg_done), 0);
`endif

    // Randomized loads, including address wrap past 2^ADDR_W words
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = $urandom_range(1, 11);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      build_stream(w, s);
      s.push_back(8'($urandom));
      send_stream(s);
      check_load("rnd", w);
    end

    // Randomized framing error after some completed words
    for (int t = 0; t < 3; t++) begin
      do_reset();
      n = $urandom_range(2, 5);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      build_stream(w, s);
      bad = $urandom_range(2, 4 * n);
      for (int i = 0; i < bad; i++) send_byte(s[i], 1'b0);
      send_byte(s[bad], 1'b1);
      for (int i = bad + 1; i < s.size(); i++) send_byte(s[i], 1'b0);
      repeat (3 * DIV + 8) @(negedge clk);
      chk("rfe_err",  32'(err), 1);
      chk("rfe_done", 32'(upg_done), 0);
      chk("rfe_nwr",  32'(wr_adr.size()), 32'((bad - 2) / 4));
      for (int i = 0; i < wr_dat.size() && i < w.size(); i++)
        chk("rfe_dat", wr_dat[i], w[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/upg_uart_loader.md
# upg_uart_loader

Serial program loader for the UART programming path: receives a byte stream on a single RX pin, assembles little-endian 32-bit words and drives the `upg_*` write port of the instruction/data memories. It sits directly upstream of the data-memory wrapper and feeds its `upg_wen_i`, `upg_adr_i`, `upg_dat_i` and `upg_done_i` inputs. The wrapper switches the RAM to CPU mode only once `upg_done_o` is high.

## Interface
- `CLK_HZ`, 10_000_000: frequency of `upg_clk_i` in Hz.
- `BAUD`, 115200: serial bit rate.
- `ADDR_W`, 14: word-address width.
- `upg_clk_i`  in  1  loader clock, 10 MHz; all logic on the rising edge.
- `upg_rst_i`  in  1  reset, synchronous, active-high.
- `rx_i`  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- `upg_wen_o`  out  1  one-cycle write strobe.
- `upg_adr_o`  out  ADDR_W  word address of the current write.
- `upg_dat_o`  out  32  write data.
- `upg_done_o`  out  1  programming finished; sticky until reset.
- `err_o`  out  1  framing or checksum error; sticky until reset.

## Operation
- RX front end:
  - 2-flop synchronizer on `rx_i`.
  - Divisor DIV = CLK_HZ/BAUD, truncating integer division; 86 at the defaults.
  - IDLE: a sampled 0 starts a counter. At DIV/2 cycles the line is rechecked. If it is high, the start is treated as a glitch and the block returns to IDLE with no side effect.
  - Data bits are then sampled every DIV cycles, LSB first. The stop bit is sampled DIV cycles after bit 7.
  - Stop bit = 1: an internal `byte_valid` pulses for 1 cycle with the byte.
  - Stop bit = 0: framing error.
- Loader FSM states: LEN0, LEN1, DATA, CSUM (macro only), DONE, ERR.
  - LEN0 and LEN1: capture the 16-bit word count N, low byte first.
    - If N = 0, go directly to DONE.
    - Otherwise go to DATA with the word index and byte index cleared.
  - DATA: each byte is shifted into the word; byte k goes to bits [8k+7:8k].
    - On the 4th byte, the word is presented with `upg_wen_o` = 1 for one cycle and the word index increments.
    - After word N-1 is written, go to DONE (or CSUM).
  - DONE: `upg_done_o` = 1. All further bytes are ignored.
  - ERR: `err_o` = 1. No further writes until reset. `upg_done_o` stays 0.
- A framing error in any loader state other than DONE forces ERR.
- Address: `upg_adr_o` = word index mod 2^ADDR_W. When N > 2^ADDR_W, addresses wrap to 0 and overwrite earlier words. No error is raised for this.

## Timing
- Reset values: `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `err_o`=0. FSM in LEN0, RX in IDLE, all counters 0.
- `upg_wen_o` rises the cycle after `byte_valid` of the 4th byte. `upg_adr_o` and `upg_dat_o` are stable during that cycle and hold until the next write.
- `upg_done_o` rises 1 cycle after the final `upg_wen_o` pulse. It never coincides with a strobe.
- With N = 0, `upg_done_o` rises 1 cycle after `byte_valid` of LEN1.
- Latency from the `rx_i` falling edge to `byte_valid` is about 9.5·DIV + 2 cycles, including the synchronizer.
- Reset asserted mid-byte or mid-word discards all partial state the same cycle. The next start bit begins a fresh LEN0.
- A back-to-back start bit immediately after a stop-bit sample is accepted.

## Configuration
- `UPG_CHECKSUM_EN` defined:
  - After word N-1, the FSM enters CSUM and expects one byte equal to the mod-256 sum of all data bytes. Length bytes are not included in the sum.
  - Match: DONE, 1 cycle after that byte's `byte_valid`.
  - Mismatch: ERR.
  - With N = 0, the expected checksum is 0x00.
- `UPG_CHECKSUM_EN` undefined:
  - There is no CSUM state and no checksum byte. DONE follows the last write as specified above.

## Test plan
Bench parameters: CLK_HZ=400, BAUD=100, giving DIV=4.
- **Two-word load:** bytes 02 00 78 56 34 12 EF BE AD DE -> writes adr 0 = 0x12345678 and adr 1 = 0xDEADBEEF, one cycle each; `upg_done_o`=1 one cycle after the second strobe; `err_o`=0.
- **Start-bit glitch:** `rx_i` low for 1 cycle -> no `byte_valid`, no state change; a following valid stream loads normally.
- **Framing error:** stop bit 0 on the third data byte -> `err_o`=1; no strobes afterwards; `upg_done_o` stays 0.
- **Reset mid-word:** reset after bytes 01 00 AA BB -> all outputs 0; a new stream 01 00 11 22 33 44 writes adr 0 = 0x44332211.
- **Zero length and trailing bytes:** bytes 00 00 -> `upg_done_o`=1 with no strobe; further bytes are ignored.
- **Checksum (with `UPG_CHECKSUM_EN`):** bytes 01 00 01 02 03 04 followed by 0x0A -> DONE; the same stream followed by 0x0B -> `err_o`=1, `upg_done_o`=0.
